// File: rtl/r_cpu_pkg.sv
// Shared types and encodings for the R-format multi-cycle sequencer.
// State enum, funct/opcode constants and ALU control codes.
package r_cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SRL = 6'h02;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_BAD = 4'b1111;

endpackage

// File: rtl/rfmt_decode.sv
// Combinational R-format decoder: IR -> ALU control, legality, NOP.
// The all-zero word is a legal NOP even though funct 0 is not supported.
module rfmt_decode
    import r_cpu_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  alu_ctrl,
    output logic        legal,
    output logic        nop
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];

    always_comb begin
        alu_ctrl = ALU_BAD;
        legal    = 1'b0;
        nop      = 1'b0;
        if (ir == 32'd0) begin
            alu_ctrl = ALU_ADD;
            legal    = 1'b1;
            nop      = 1'b1;
        end else if (opcode == OP_RTYPE) begin
            legal = 1'b1;
            unique case (1'b1)
                (funct == FN_ADD): alu_ctrl = ALU_ADD;
                (funct == FN_SUB): alu_ctrl = ALU_SUB;
                (funct == FN_AND): alu_ctrl = ALU_AND;
                (funct == FN_OR):  alu_ctrl = ALU_OR;
                (funct == FN_SLT): alu_ctrl = ALU_SLT;
                (funct == FN_SRL): alu_ctrl = ALU_SRL;
                default: begin
                    alu_ctrl = ALU_BAD;
                    legal    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/r_format_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-format datapath.
// Owns PC, IR, retire counter and the sticky illegal-instruction flag.
module r_format_seq_ctrl
    import r_cpu_pkg::*;
#(
    parameter int INSTR_MAX = 128,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic            ir_we,
    output logic            alu_we,
    output logic            reg_write,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [3:0]      alu_ctrl,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [7:0]      instr_count
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(INSTR_MAX - 4);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    state_t      state;
    logic [31:0] ir;
    logic [3:0]  alu_q;
    logic        legal_q;
    logic        nop_q;
    logic [3:0]  dec_alu;
    logic        dec_legal;
    logic        dec_nop;

    rfmt_decode u_dec (
        .ir       (ir),
        .alu_ctrl (dec_alu),
        .legal    (dec_legal),
        .nop      (dec_nop)
    );

    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];

    // DECODE shows the live decode; it is held from EXEC onward.
    assign alu_ctrl  = (state == S_DECODE) ? dec_alu : alu_q;
    assign ir_we     = (state == S_FETCH);
    assign alu_we    = (state == S_EXEC);
    assign reg_write = (state == S_WB) && legal_q && !nop_q && (rd != 5'd0);
    assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                       (state == S_EXEC)  || (state == S_WB);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            alu_q       <= '0;
            legal_q     <= 1'b0;
            nop_q       <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_FETCH;
                        pc          <= '0;
                        illegal     <= 1'b0;
                        instr_count <= '0;
                    end
                end
                S_FETCH: begin
                    ir    <= instr;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    alu_q   <= dec_alu;
                    legal_q <= dec_legal;
                    nop_q   <= dec_nop;
                    if (!dec_legal)
                        illegal <= 1'b1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_WB;
                end
                S_WB: begin
                    if (instr_count != 8'hFF)
                        instr_count <= instr_count + 8'd1;
                    if (pc == PC_LAST) begin
                        state <= S_DONE;
                    end else begin
                        pc    <= pc + PC_STEP;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
